// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode constants and fetch FSM state type
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam int RET_BUBBLES = 3;

  typedef enum logic [2:0] {
    FS_IDLE = 3'd0,
    FS_RET1 = 3'd1,
    FS_RET2 = 3'd2,
    FS_RET3 = 3'd3,
    FS_HALT = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_predict.sv
// rtl/pc_predict.sv - always-taken next-PC prediction mux
module pc_predict
  import y86_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [3:0]        i_icode,
  input  logic [ADDR_W-1:0] i_valC,
  input  logic [ADDR_W-1:0] i_valP,
  output logic [ADDR_W-1:0] o_predPC
);

  // Jumps and calls are predicted taken; anything else, including
  // undefined icodes, falls through sequentially.
  assign o_predPC = ((i_icode == IJXX) || (i_icode == ICALL)) ? i_valC : i_valP;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - F-stage PC select, ret bubble insertion and halt freeze
module fetch_pc_ctrl
  import y86_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              F_stall,
  input  logic [3:0]        M_icode,
  input  logic              M_cnd,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [ADDR_W-1:0] W_valM,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_valid,
  output logic [ADDR_W-1:0] f_predPC,
  output logic [ADDR_W-1:0] F_predPC,
  output logic              ret_pending,
  output logic              halted
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_predpc;
  logic              w_mispredict;
  logic              w_load_pred;

  assign w_mispredict = (M_icode == IJXX) && !M_cnd;

  assign f_pc = w_mispredict        ? M_valA :
                (W_icode == IRET)   ? W_valM :
                                      r_predpc;

  assign f_valid     = w_mispredict || (r_state == FS_IDLE);
  assign ret_pending = (r_state == FS_RET1) || (r_state == FS_RET2) || (r_state == FS_RET3);
  assign halted      = (r_state == FS_HALT);
  assign F_predPC    = r_predpc;

  pc_predict #(.ADDR_W(ADDR_W)) u_pc_predict (
    .i_icode  (f_icode),
    .i_valC   (f_valC),
    .i_valP   (f_valP),
    .o_predPC (f_predPC)
  );

  // A mispredict overrides everything, so a ret or halt fetched on the
  // wrong path never takes effect.
  always_comb begin
    w_state_nxt = r_state;
    if (w_mispredict) begin
      w_state_nxt = FS_IDLE;
    end else if (!F_stall) begin
      case (r_state)
        FS_IDLE: begin
          if (f_icode == IRET)       w_state_nxt = FS_RET1;
          else if (f_icode == IHALT) w_state_nxt = FS_HALT;
        end
        FS_RET1: w_state_nxt = FS_RET2;
        FS_RET2: w_state_nxt = FS_RET3;
        FS_RET3: w_state_nxt = FS_IDLE;
        FS_HALT: w_state_nxt = FS_HALT;
        default: w_state_nxt = FS_IDLE;
      endcase
    end
  end

  assign w_load_pred = (f_valid && !F_stall) || w_mispredict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FS_IDLE;
      r_predpc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_pred) r_predpc <= f_predPC;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - scoreboard bench for fetch_pc_ctrl against a cycle-level reference model
module tb_fetch_pc_ctrl;

  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        F_stall;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [63:0] f_pc;
  logic        f_valid;
  logic [63:0] f_predPC;
  logic [63:0] F_predPC;
  logic        ret_pending;
  logic        halted;

  fetch_pc_ctrl #(.ADDR_W(64), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_pc(f_pc), .f_valid(f_valid), .f_predPC(f_predPC), .F_predPC(F_predPC),
    .ret_pending(ret_pending), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] fpc;
    logic        valid;
    logic [63:0] pred;
    logic [63:0] freg;
    logic        retp;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: bubbles still owed after a ret, halt flag, predicted PC.
  int          m_bubbles = 0;
  bit          m_halted  = 0;
  logic [63:0] m_pred    = RST_PC;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic drive(input logic [3:0] fi, input logic [63:0] vc, input logic [63:0] vp,
                       input logic [3:0] mi, input logic mc, input logic [63:0] ma,
                       input logic [3:0] wi, input logic [63:0] wm, input logic st);
    exp_t e;
    bit   mis;
    logic [63:0] guess;
    @(posedge clk); #1;
    f_icode = fi; f_valC = vc; f_valP = vp;
    M_icode = mi; M_cnd = mc; M_valA = ma;
    W_icode = wi; W_valM = wm; F_stall = st;

    mis   = (mi == 4'd7) && !mc;
    guess = (fi == 4'd7 || fi == 4'd8) ? vc : vp;
    e.fpc   = mis ? ma : (wi == 4'd9) ? wm : m_pred;
    e.valid = mis || (m_bubbles == 0 && !m_halted);
    e.pred  = guess;
    e.freg  = m_pred;
    e.retp  = (m_bubbles > 0);
    e.halt  = m_halted;
    exp_q.push_back(e);

    if (mis) begin
      m_bubbles = 0; m_halted = 0; m_pred = guess;
    end else if (st) begin
      // frozen
    end else if (m_bubbles > 0) begin
      m_bubbles--;
    end else if (!m_halted) begin
      m_pred = guess;
      if (fi == 4'd9)      m_bubbles = 3;
      else if (fi == 4'd0) m_halted = 1;
    end
  endtask

  // Plain fetch with no redirects.
  task automatic fetch(input logic [3:0] fi, input logic [63:0] vc, input logic [63:0] vp);
    drive(fi, vc, vp, 4'd1, 1'b1, 64'h0, 4'd1, 64'h0, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    M_icode = 4'd1; W_icode = 4'd1; f_icode = 4'd1; F_stall = 1'b1;
    #1;
    check({tag, "_f_pc"},     f_pc,               RST_PC);
    check({tag, "_f_valid"},  {63'd0, f_valid},   64'd1);
    check({tag, "_F_predPC"}, F_predPC,           RST_PC);
    check({tag, "_ret_pend"}, {63'd0, ret_pending}, 64'd0);
    check({tag, "_halted"},   {63'd0, halted},    64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("f_pc",        f_pc,                 e.fpc);
        check("f_valid",     {63'd0, f_valid},     {63'd0, e.valid});
        check("f_predPC",    f_predPC,             e.pred);
        check("F_predPC",    F_predPC,             e.freg);
        check("ret_pending", {63'd0, ret_pending}, {63'd0, e.retp});
        check("halted",      {63'd0, halted},      {63'd0, e.halt});
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    F_stall = 1'b1; M_icode = 4'd1; M_cnd = 1'b1; M_valA = '0;
    W_icode = 4'd1; W_valM = '0; f_icode = 4'd1; f_valC = '0; f_valP = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_check("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    fetch(4'd6, 64'h55, 64'h2);
    fetch(4'd8, 64'h100, 64'h10b);
    fetch(4'd7, 64'h80, 64'h19);
    fetch(4'd1, 64'h0, 64'h81);
    drive(4'd6, 64'h0, 64'h1b, 4'd7, 1'b0, 64'h19, 4'd1, 64'h0, 1'b0);
    fetch(4'd9, 64'h0, 64'h1c);
    for (int i = 0; i < 3; i++) fetch(4'd9, 64'hdead, 64'hbeef);
    drive(4'd1, 64'h0, 64'h41, 4'd1, 1'b1, 64'h0, 4'd9, 64'h40, 1'b0);
    fetch(4'd9, 64'h0, 64'h42);
    drive(4'd6, 64'h0, 64'h32, 4'd7, 1'b0, 64'h30, 4'd1, 64'h0, 1'b0);
    fetch(4'd6, 64'h0, 64'h34);
    fetch(4'd0, 64'h0, 64'h35);
    for (int i = 0; i < 12; i++) fetch(4'(i), 64'h77, 64'h88);
    drive(4'd1, 64'h0, 64'h51, 4'd7, 1'b0, 64'h50, 4'd1, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) drive(4'd6, 64'h0, 64'h99, 4'd1, 1'b1, 64'h0, 4'd1, 64'h0, 1'b1);
    fetch(4'd6, 64'h0, 64'h53);
    fetch(4'd9, 64'h0, 64'h54);
    fetch(4'd6, 64'h0, 64'h60);
    fetch(4'd6, 64'h0, 64'h61);
    @(negedge clk); #1;
    rst_n = 1'b0;
    reset_check("midret");
    m_bubbles = 0; m_halted = 0; m_pred = RST_PC;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [3:0] mi;
      mi = ($urandom_range(0, 5) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      drive(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
            mi, 1'($urandom_range(0, 1)), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 15)), {$urandom, $urandom},
            ($urandom_range(0, 5) == 0));
    end

    @(negedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
